// File: rtl/rv32i_types.sv
// Shared defaults and types for the renaming register file: data/tag widths,
// register index and the per-port commit bundle.
package rv32i_types;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int TAG_W_DEF = 3;
  localparam int REG_IDX_W = $clog2(NREGS_DEF);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;
  typedef logic [XLEN_DEF-1:0]  xdata_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    tag_t     tag;
    xdata_t   data;
  } cmt_port_t;

endpackage

// File: rtl/regfile_rename_popcount.sv
// Population count of an N-bit vector; feeds the registered busy counter.
module popcount #(
  parameter int N = 32
) (
  input  logic [N-1:0]             i_vec,
  output logic [$clog2(N+1)-1:0]   o_count
);

  localparam int CW = $clog2(N+1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with rename tags: in-order ROB commits write data,
// allocations mark registers busy under a new tag, reads bypass same-cycle commits.
module regfile_rename
  import rv32i_types::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = 3,
  parameter int NCMT  = 2
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_alloc_valid,
  input  logic [$clog2(NREGS)-1:0]                i_alloc_rd,
  input  logic [TAG_W-1:0]                        i_alloc_tag,
  input  logic [NCMT-1:0]                         i_cmt_valid,
  input  logic [NCMT-1:0][$clog2(NREGS)-1:0]      i_cmt_rd,
  input  logic [NCMT-1:0][TAG_W-1:0]              i_cmt_tag,
  input  logic [NCMT-1:0][XLEN-1:0]               i_cmt_data,
  input  logic                                    i_flush,
  input  logic [NRD-1:0][$clog2(NREGS)-1:0]       i_rd_addr,
  output logic [NRD-1:0][XLEN-1:0]                o_rd_data,
  output logic [NRD-1:0]                          o_rd_ready,
  output logic [NRD-1:0][TAG_W-1:0]               o_rd_tag,
  output logic [$clog2(NREGS+1)-1:0]              o_busy_count
);

  localparam int CW = $clog2(NREGS+1);

  logic [XLEN-1:0]  r_data [NREGS];
  logic [TAG_W-1:0] r_tag  [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_busy_count;

  logic [XLEN-1:0]  w_data_nxt [NREGS];
  logic [TAG_W-1:0] w_tag_nxt  [NREGS];
  logic [NREGS-1:0] w_busy_nxt;
  logic [CW-1:0]    w_busy_count_nxt;

  // Later commit ports override earlier ones, so the highest index decides
  // both the written data and whether the busy bit is released.
  always_comb begin
    w_data_nxt = r_data;
    w_tag_nxt  = r_tag;
    w_busy_nxt = r_busy;
    for (int k = 0; k < NCMT; k++) begin
      if (i_cmt_valid[k] && i_cmt_rd[k] != '0) begin
        w_data_nxt[i_cmt_rd[k]] = i_cmt_data[k];
        w_busy_nxt[i_cmt_rd[k]] = (i_cmt_tag[k] == r_tag[i_cmt_rd[k]]) ? 1'b0 : r_busy[i_cmt_rd[k]];
      end
    end
    if (i_alloc_valid && i_alloc_rd != '0 && !i_flush) begin
      w_busy_nxt[i_alloc_rd] = 1'b1;
      w_tag_nxt[i_alloc_rd]  = i_alloc_tag;
    end
    if (i_flush) begin
      w_busy_nxt = '0;
    end
  end

  popcount #(.N(NREGS)) u_popcount (
    .i_vec   (w_busy_nxt),
    .o_count (w_busy_count_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_data[r] <= '0;
        r_tag[r]  <= '0;
      end
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_data       <= w_data_nxt;
      r_tag        <= w_tag_nxt;
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_count_nxt;
    end
  end

  assign o_busy_count = r_busy_count;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [XLEN-1:0]  w_data;
    logic             w_ready;
    logic [TAG_W-1:0] w_tag;

    always_comb begin
      w_data  = r_data[i_rd_addr[i]];
      w_ready = !r_busy[i_rd_addr[i]];
      w_tag   = r_tag[i_rd_addr[i]];
      for (int k = 0; k < NCMT; k++) begin
        if (i_cmt_valid[k] && i_cmt_rd[k] == i_rd_addr[i]) begin
          w_data  = i_cmt_data[k];
          w_ready = (i_cmt_tag[k] == r_tag[i_rd_addr[i]]) ? 1'b1 : !r_busy[i_rd_addr[i]];
        end
      end
      // x0 and an asserted reset both present the cleared view.
      if (i_rd_addr[i] == '0 || !i_rst_n) begin
        w_data  = '0;
        w_ready = 1'b1;
        w_tag   = '0;
      end
    end

    assign o_rd_data[i]  = w_data;
    assign o_rd_ready[i] = w_ready;
    assign o_rd_tag[i]   = w_tag;
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios with literal
// expectations, then randomized traffic checked against a register-level model.
module tb_regfile_rename;
  import rv32i_types::*;

  localparam int XLEN = 32, NREGS = 32, TAG_W = 3, NRD = 3, NCMT = 2;
  localparam int RW = 5, CW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                         alloc_valid;
  logic [RW-1:0]                alloc_rd;
  logic [TAG_W-1:0]             alloc_tag;
  logic [NCMT-1:0]              cmt_valid;
  logic [NCMT-1:0][RW-1:0]      cmt_rd;
  logic [NCMT-1:0][TAG_W-1:0]   cmt_tag;
  logic [NCMT-1:0][XLEN-1:0]    cmt_data;
  logic                         flush;
  logic [NRD-1:0][RW-1:0]       rd_addr;
  logic [NRD-1:0][XLEN-1:0]     rd_data;
  logic [NRD-1:0]               rd_ready;
  logic [NRD-1:0][TAG_W-1:0]    rd_tag;
  logic [CW-1:0]                busy_count;

  regfile_rename #(.XLEN(XLEN), .NREGS(NREGS), .TAG_W(TAG_W), .NRD(NRD), .NCMT(NCMT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alloc_valid(alloc_valid), .i_alloc_rd(alloc_rd), .i_alloc_tag(alloc_tag),
    .i_cmt_valid(cmt_valid), .i_cmt_rd(cmt_rd), .i_cmt_tag(cmt_tag), .i_cmt_data(cmt_data),
    .i_flush(flush), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_ready(rd_ready), .o_rd_tag(rd_tag), .o_busy_count(busy_count)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: one entry per architectural register.
  logic [XLEN-1:0]  m_data [NREGS];
  logic [TAG_W-1:0] m_tag  [NREGS];
  bit               m_busy [NREGS];
  int               m_count;

  function automatic int last_commit_to(input int r);
    int w = -1;
    for (int k = 0; k < NCMT; k++)
      if (cmt_valid[k] && int'(cmt_rd[k]) == r) w = k;
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        m_data[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
      end
      m_count = 0;
    end else begin
      m_count = 0;
      for (int r = 1; r < NREGS; r++) begin
        int  w;
        bit  nb;
        logic [TAG_W-1:0] nt;
        w  = last_commit_to(r);
        nb = m_busy[r];
        nt = m_tag[r];
        if (w >= 0) begin
          m_data[r] = cmt_data[w];
          if (cmt_tag[w] == m_tag[r]) nb = 1'b0;
        end
        if (alloc_valid && int'(alloc_rd) == r && !flush) begin
          nb = 1'b1; nt = alloc_tag;
        end
        if (flush) nb = 1'b0;
        m_busy[r] = nb;
        m_tag[r]  = nt;
        m_count  += int'(nb);
      end
    end
  end

  task automatic model_read(input int a, output logic [XLEN-1:0] d, output logic rdy,
                            output logic [TAG_W-1:0] t);
    int w;
    if (a == 0 || !rst_n) begin
      d = '0; rdy = 1'b1; t = '0;
    end else begin
      w   = last_commit_to(a);
      t   = m_tag[a];
      d   = (w >= 0) ? cmt_data[w] : m_data[a];
      rdy = (w >= 0 && cmt_tag[w] == m_tag[a]) ? 1'b1 : !m_busy[a];
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        logic [XLEN-1:0] d; logic rdy; logic [TAG_W-1:0] t;
        model_read(int'(rd_addr[i]), d, rdy, t);
        chk($sformatf("cyc_rd_data[%0d] x%0d", i, rd_addr[i]), rd_data[i], d);
        chk($sformatf("cyc_rd_ready[%0d] x%0d", i, rd_addr[i]), 32'(rd_ready[i]), 32'(rdy));
        chk($sformatf("cyc_rd_tag[%0d] x%0d", i, rd_addr[i]), 32'(rd_tag[i]), 32'(t));
      end
      chk("cyc_busy_count", 32'(busy_count), rst_n ? m_count : 0);
    end
  end

  task automatic idle();
    cmt_port_t z;
    z = '0;
    alloc_valid = 1'b0; alloc_rd = '0; alloc_tag = '0; flush = 1'b0;
    for (int k = 0; k < NCMT; k++) begin
      cmt_valid[k] = z.valid; cmt_rd[k] = z.rd; cmt_tag[k] = z.tag; cmt_data[k] = z.data;
    end
    rd_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmt(input int k, input int rd, input int tag, input logic [31:0] data);
    cmt_valid[k] = 1'b1; cmt_rd[k] = RW'(rd); cmt_tag[k] = TAG_W'(tag); cmt_data[k] = data;
  endtask

  task automatic set_alloc(input int rd, input int tag);
    alloc_valid = 1'b1; alloc_rd = RW'(rd); alloc_tag = TAG_W'(tag);
  endtask

  function automatic logic [RW-1:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? RW'($urandom_range(0, NREGS-1)) : RW'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Reset state
    rd_addr[0] = 5; #1;
    chk("rst_x5_data", rd_data[0], 32'h0);
    chk("rst_x5_ready", 32'(rd_ready[0]), 1);
    chk("rst_x5_tag", 32'(rd_tag[0]), 0);
    chk("rst_busy_count", 32'(busy_count), 0);

    // Alloc then matching commit with same-cycle bypass
    idle(); set_alloc(5, 3); step();
    idle(); rd_addr[0] = 5; #1;
    chk("a5_ready", 32'(rd_ready[0]), 0);
    chk("a5_tag", 32'(rd_tag[0]), 3);
    chk("a5_busy_count", 32'(busy_count), 1);
    set_cmt(0, 5, 3, 32'hDEADBEEF); #1;
    chk("c5_bypass_data", rd_data[0], 32'hDEADBEEF);
    chk("c5_bypass_ready", 32'(rd_ready[0]), 1);
    step(); idle(); rd_addr[0] = 5; #1;
    chk("c5_busy_count", 32'(busy_count), 0);
    chk("c5_data", rd_data[0], 32'hDEADBEEF);

    // Stale-tag commit does not release the register
    idle(); set_alloc(7, 1); step();
    idle(); set_alloc(7, 4); step();
    idle(); set_cmt(0, 7, 1, 32'h11); step();
    idle(); rd_addr[1] = 7; #1;
    chk("x7_stale_data", rd_data[1], 32'h11);
    chk("x7_stale_ready", 32'(rd_ready[1]), 0);
    chk("x7_stale_tag", 32'(rd_tag[1]), 4);
    set_cmt(1, 7, 4, 32'h22); step();
    idle(); rd_addr[1] = 7; #1;
    chk("x7_final_ready", 32'(rd_ready[1]), 1);
    chk("x7_final_data", rd_data[1], 32'h22);

    // Two commit ports to one register: highest index wins
    idle(); set_alloc(9, 2); step();
    idle(); set_cmt(0, 9, 2, 32'hA); set_cmt(1, 9, 2, 32'hB); rd_addr[2] = 9; #1;
    chk("x9_bypass_data", rd_data[2], 32'hB);
    step(); idle(); rd_addr[2] = 9; #1;
    chk("x9_data", rd_data[2], 32'hB);
    chk("x9_ready", 32'(rd_ready[2]), 1);

    // Flush drops same-cycle alloc but keeps commit data
    idle(); set_alloc(1, 1); step();
    idle(); set_alloc(2, 2); step();
    idle(); set_alloc(3, 3); step();
    idle(); #1;
    chk("pre_flush_busy_count", 32'(busy_count), 3);
    flush = 1'b1; set_alloc(4, 5); set_cmt(0, 2, 0, 32'h55); step();
    idle(); rd_addr[0] = 1; rd_addr[1] = 2; rd_addr[2] = 4; #1;
    chk("flush_x1_ready", 32'(rd_ready[0]), 1);
    chk("flush_x2_ready", 32'(rd_ready[1]), 1);
    chk("flush_x2_data", rd_data[1], 32'h55);
    chk("flush_x4_ready", 32'(rd_ready[2]), 1);
    chk("flush_busy_count", 32'(busy_count), 0);

    // x0 writes ignored, then async reset mid-sequence
    idle(); set_alloc(6, 1); step();
    idle(); set_alloc(0, 2); set_cmt(0, 0, 0, 32'hFF); #1;
    chk("x0_bypass_data", rd_data[0], 32'h0);
    step(); idle(); #1;
    chk("x0_data", rd_data[0], 32'h0);
    chk("x0_ready", 32'(rd_ready[0]), 1);
    chk("x0_tag", 32'(rd_tag[0]), 0);
    chk("x0_busy_count", 32'(busy_count), 1);
    rd_addr[0] = 6; rd_addr[1] = 5; #1;
    rst_n = 1'b0; #1;
    chk("midrst_busy_count", 32'(busy_count), 0);
    chk("midrst_x6_ready", 32'(rd_ready[0]), 1);
    chk("midrst_x5_data", rd_data[1], 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(); #1;
    chk("postrst_x5_data", rd_data[1], 32'h0);
    chk("postrst_x6_ready", 32'(rd_ready[0]), 1);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) set_alloc(int'(rand_reg()), int'($urandom_range(0, 7)));
      for (int k = 0; k < NCMT; k++) begin
        if ($urandom_range(0, 2) != 0) begin
          logic [RW-1:0] r;
          r = rand_reg();
          set_cmt(k, int'(r), ($urandom_range(0, 2) != 0) ? int'(m_tag[r]) : int'($urandom_range(0, 7)),
                  $urandom);
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NRD; i++) rd_addr[i] = rand_reg();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 Parameter XLEN, default 32, data width per architectural register.
REQ-002 Parameter NREGS, default 32, number of architectural registers; register 0 hardwired to zero.
REQ-003 Parameter TAG_W, default 3, ROB tag width.
REQ-004 Parameter NRD, default 3, number of independent read ports (src_a, src_b, store data).
REQ-005 Parameter NCMT, default 2, number of commit (writeback) ports per cycle.
REQ-006 Ports: one clock; reset is asynchronous and active-low. clk input 1, rising-edge clock. rst input 1, asynchronous active-low reset.
REQ-007 alloc_valid input 1; alloc_rd input log2(NREGS); alloc_tag input TAG_W: rename alloc_rd to alloc_tag, mark busy.
REQ-008 cmt_valid input [NCMT]x1; cmt_rd input [NCMT]x log2(NREGS); cmt_tag input [NCMT]xTAG_W; cmt_data input [NCMT]xXLEN: in-order ROB commits.
REQ-009 flush input 1: pipeline flush; all pending renames discarded.
REQ-010 rd_addr input [NRD]x log2(NREGS); rd_data output [NRD]xXLEN; rd_ready output [NRD]x1; rd_tag output [NRD]xTAG_W.
REQ-011 busy_count output $clog2(NREGS+1): registered number of busy registers.

Function
REQ-012 Per register: data (XLEN), tag (TAG_W), busy (1); ready = !busy.
REQ-013 Commit port k with cmt_valid[k] and cmt_rd[k]!=0 SHALL write cmt_data[k] to data at next edge.
REQ-014 Commit port k SHALL clear busy only if cmt_tag[k] equals the stored tag of cmt_rd[k]; otherwise busy unchanged.
REQ-015 Two commit ports targeting the same register in one cycle: highest-index port wins data and tag compare.
REQ-016 alloc_valid with alloc_rd!=0 and flush=0 SHALL set busy=1 and tag=alloc_tag at next edge.
REQ-017 Alloc and commit to same register in same cycle: data from commit written; busy=1 and tag=alloc_tag (alloc wins).
REQ-018 flush=1 SHALL clear busy for all registers at next edge and drop any same-cycle alloc; same-cycle commits still write data.
REQ-019 Writes to register 0 ignored; reads of register 0 return data 0, ready 1, tag 0.
REQ-020 Reads combinational, zero latency; each port independent.
REQ-021 Bypass: if a valid commit targets rd_addr[i] this cycle, rd_data[i] SHALL be that commit's data (highest-index port), rd_ready[i]=1 iff its tag matches stored tag, else stored ready.
REQ-022 Reads SHALL NOT observe same-cycle alloc (decode handles intra-bundle dependence).
REQ-023 rd_tag[i] SHALL always be the stored tag, regardless of busy.
REQ-024 busy_count SHALL equal the population count of busy bits after each edge; 0 after flush.

Reset
REQ-025 rst low SHALL asynchronously set all data=0, tag=0, busy=0, busy_count=0.
REQ-026 Reset deassertion mid-stream: first edge after rst high processes inputs normally; no operation straddles reset.
REQ-027 Outputs during reset: rd_data=0, rd_ready=1, rd_tag=0 for all ports.

Structure
REQ-028 XLEN/TAG_W defaults, reg index and tag typedefs, and commit-port struct SHALL live in shared package rv32i_types.
REQ-029 One sub-module, popcount (NREGS-bit population count), SHALL compute next busy_count.
REQ-030 Bypass/priority logic SHALL be generated loops over NRD and NCMT; no hard-coded port count.

Verification
REQ-031 Reset, read x5 -> rd_data 0, rd_ready 1, rd_tag 0, busy_count 0.
REQ-032 Alloc x5 tag 3; next cycle read x5 -> ready 0, tag 3, busy_count 1; commit x5 tag 3 data 0xDEADBEEF -> same-cycle read returns 0xDEADBEEF ready 1; next cycle busy_count 0.
REQ-033 Alloc x7 tag 1 then tag 4; commit x7 tag 1 data 0x11 -> data 0x11, ready 0, tag 4; commit tag 4 data 0x22 -> ready 1.
REQ-034 Same cycle: cmt port0 x9 data 0xA, port1 x9 data 0xB, tag match -> x9 = 0xB, ready 1.
REQ-035 Alloc x1,x2,x3 (busy_count 3); flush with alloc x4 and commit x2 data 0x55 -> all ready, x4 not busy, x2=0x55, busy_count 0.
REQ-036 Alloc x0 tag 2 and commit x0 data 0xFF -> read x0 returns 0, ready 1, busy_count unchanged; rst asserted mid-sequence clears everything immediately.
